// File: rtl/score_tally_if.sv
// score_tally_if: game-control inputs and score outputs of score_tally
interface score_tally_if #(
  parameter int N_LANES = 8
);
  logic [7:0]         keycode;
  logic [N_LANES-1:0] score_in;
  logic               end_game;
  logic [13:0]        score;
  logic [7:0]         combo;
  logic [7:0]         max_combo;
  logic [13:0]        high_score;
  logic               game_over;
  modport master (
    output keycode, score_in, end_game,
    input  score, combo, max_combo, high_score, game_over
  );
  modport slave (
    input  keycode, score_in, end_game,
    output score, combo, max_combo, high_score, game_over
  );
endinterface

// File: rtl/score_tally.sv
// score_tally: rhythm-game score, combo, max-combo and high-score keeper
module score_tally #(
  parameter int N_LANES       = 8,
  parameter int COMBO_TIMEOUT = 120,
  parameter int BONUS_COMBO   = 10,
  parameter int SCORE_MAX     = 9999
) (
  input logic          frame_clk,
  input logic          Reset,
  score_tally_if.slave bus
);
  localparam int HW = $clog2(N_LANES + 1);
  localparam int TW = $clog2(COMBO_TIMEOUT + 1);
  localparam logic [7:0]    BONUS   = 8'(BONUS_COMBO);
  localparam logic [13:0]   SMAX    = 14'(SCORE_MAX);
  localparam logic [TW-1:0] TMO_END = TW'(COMBO_TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, PLAYING, DONE} state_t;
  state_t             state, state_nx;
  logic [N_LANES-1:0] prev_in;
  logic [TW-1:0]      tmo, tmo_nx;
  logic [HW-1:0]      hits;
  logic [HW:0]        pts;
  logic [14:0]        sum;
  logic [8:0]         csum;
  logic [13:0]        score_nx, high_nx, score_hit;
  logic [7:0]         combo_nx, max_nx, combo_hit;
  logic               game_over_nx;
  // Rising flags only count while playing; prev_in is tracked in every state
  always_comb begin
    hits = '0;
    for (int i = 0; i < N_LANES; i++)
      hits = hits + HW'(bus.score_in[i] & ~prev_in[i] & (state == PLAYING));
  end
  assign pts       = (bus.combo >= BONUS) ? {hits, 1'b0} : {1'b0, hits};
  assign sum       = {1'b0, bus.score} + 15'(pts);
  assign score_hit = (sum >= 15'(SCORE_MAX)) ? SMAX : sum[13:0];
  assign csum      = {1'b0, bus.combo} + 9'(hits);
  assign combo_hit = csum[8] ? 8'hff : csum[7:0];
  // Game phase register
  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else state <= state_nx;
  end
  // Phase transitions driven by keys and end of chart
  always_comb begin
    state_nx = state;
    if (state == IDLE && bus.keycode == 8'h2c) state_nx = PLAYING;
    else if (state == PLAYING && bus.end_game) state_nx = DONE;
    else if (state == DONE && bus.keycode == 8'h01) state_nx = IDLE;
  end
  // Next values of the scoring registers; hits are scored before the end-of-game high-score check
  always_comb begin
    score_nx     = bus.score;
    combo_nx     = bus.combo;
    max_nx       = bus.max_combo;
    high_nx      = bus.high_score;
    tmo_nx       = tmo;
    game_over_nx = state_nx == DONE;
    if (state == IDLE && bus.keycode == 8'h2c) begin
      score_nx = '0;
      combo_nx = '0;
      max_nx   = '0;
      tmo_nx   = '0;
    end else if (state == PLAYING) begin
      if (hits != '0) begin
        score_nx = score_hit;
        combo_nx = combo_hit;
        tmo_nx   = '0;
      end else begin
        tmo_nx   = (tmo == TMO_END) ? '0 : tmo + 1'b1;
        combo_nx = (tmo == TMO_END) ? '0 : bus.combo;
      end
      max_nx  = (combo_nx > bus.max_combo) ? combo_nx : bus.max_combo;
      high_nx = (state_nx == DONE && score_nx > bus.high_score) ? score_nx : bus.high_score;
    end
  end
  // Registered outputs and edge-detect history
  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      prev_in        <= '0;
      tmo            <= '0;
      bus.score      <= '0;
      bus.combo      <= '0;
      bus.max_combo  <= '0;
      bus.high_score <= '0;
      bus.game_over  <= 1'b0;
    end else begin
      prev_in        <= bus.score_in;
      tmo            <= tmo_nx;
      bus.score      <= score_nx;
      bus.combo      <= combo_nx;
      bus.max_combo  <= max_nx;
      bus.high_score <= high_nx;
      bus.game_over  <= game_over_nx;
    end
  end
endmodule

// File: tb/tb_score_tally.sv
// tb_score_tally: table vectors plus scoreboarded game sequences for score_tally
module tb_score_tally;
  typedef struct {
    logic [7:0] kc;
    logic [7:0] sin;
    logic       eg;
    int sc, cb, mx, hs, go;
  } vec_t;
  typedef struct {
    int sc, cb, mx, hs, go;
  } exp_t;
  logic frame_clk = 1'b0;
  logic Reset;
  int n_cmp = 0, n_bad = 0, n_frame = 0;
  exp_t sb[$];
  vec_t tbl[19];
  int m_st = 0, m_score = 0, m_combo = 0, m_max = 0, m_hs = 0, m_tmo = 0;
  logic [7:0] m_prev = '0;
  score_tally_if #(.N_LANES(8)) bus ();
  score_tally #(.N_LANES(8), .COMBO_TIMEOUT(120), .BONUS_COMBO(10), .SCORE_MAX(9999)) dut (
    .frame_clk(frame_clk),
    .Reset(Reset),
    .bus(bus)
  );
  always #5 frame_clk = ~frame_clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end
  function automatic void chk(string nm, int act, int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s frame %0d: got %0d want %0d", nm, n_frame, act, want);
    end
  endfunction
  task automatic model(input logic [7:0] kc, input logic [7:0] sin, input logic eg);
    int h;
    h = 0;
    for (int i = 0; i < 8; i++) if (m_st == 1 && sin[i] && !m_prev[i]) h++;
    if (m_st == 0) begin
      if (kc == 8'h2c) begin
        m_st = 1; m_score = 0; m_combo = 0; m_max = 0; m_tmo = 0;
      end
    end else if (m_st == 1) begin
      if (h > 0) begin
        m_score += h * (m_combo >= 10 ? 2 : 1);
        if (m_score > 9999) m_score = 9999;
        m_combo += h;
        if (m_combo > 255) m_combo = 255;
        m_tmo = 0;
      end else begin
        m_tmo++;
        if (m_tmo == 120) begin m_combo = 0; m_tmo = 0; end
      end
      if (m_combo > m_max) m_max = m_combo;
      if (eg) begin
        m_st = 2;
        if (m_score > m_hs) m_hs = m_score;
      end
    end else if (kc == 8'h01) m_st = 0;
    m_prev = sin;
  endtask
  task automatic compare_out();
    exp_t x;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
      return;
    end
    x = sb.pop_front();
    chk("score", int'(bus.score), x.sc);
    chk("combo", int'(bus.combo), x.cb);
    chk("max_combo", int'(bus.max_combo), x.mx);
    chk("high_score", int'(bus.high_score), x.hs);
    chk("game_over", int'(bus.game_over), x.go);
  endtask
  task automatic run(input logic [7:0] kc, input logic [7:0] sin, input logic eg,
                     input bit own, input exp_t e);
    exp_t m;
    @(negedge frame_clk);
    bus.keycode = kc;
    bus.score_in = sin;
    bus.end_game = eg;
    model(kc, sin, eg);
    m.sc = m_score; m.cb = m_combo; m.mx = m_max; m.hs = m_hs; m.go = (m_st == 2) ? 1 : 0;
    sb.push_back(own ? e : m);
    @(posedge frame_clk);
    #1;
    n_frame++;
    compare_out();
  endtask
  task automatic step(input logic [7:0] kc, input logic [7:0] sin, input logic eg);
    exp_t none;
    none = '{0, 0, 0, 0, 0};
    run(kc, sin, eg, 1'b0, none);
  endtask
  task automatic pulse(input logic [7:0] mask);
    step(8'h00, mask, 1'b0);
    step(8'h00, 8'h00, 1'b0);
  endtask
  initial begin
    exp_t e;
    tbl[0]  = '{8'h00, 8'h00, 1'b0,  0,  0,  0,  0, 0};
    tbl[1]  = '{8'h2c, 8'h00, 1'b0,  0,  0,  0,  0, 0};
    tbl[2]  = '{8'h00, 8'h01, 1'b0,  1,  1,  1,  0, 0};
    tbl[3]  = '{8'h00, 8'h01, 1'b0,  1,  1,  1,  0, 0};
    tbl[4]  = '{8'h00, 8'h00, 1'b0,  1,  1,  1,  0, 0};
    tbl[5]  = '{8'h00, 8'hff, 1'b0,  9,  9,  9,  0, 0};
    tbl[6]  = '{8'h00, 8'h00, 1'b0,  9,  9,  9,  0, 0};
    tbl[7]  = '{8'h00, 8'h29, 1'b0, 12, 12, 12,  0, 0};
    tbl[8]  = '{8'h00, 8'h00, 1'b0, 12, 12, 12,  0, 0};
    tbl[9]  = '{8'h00, 8'h01, 1'b0, 14, 13, 13,  0, 0};
    tbl[10] = '{8'h2c, 8'h01, 1'b0, 14, 13, 13,  0, 0};
    tbl[11] = '{8'h01, 8'h00, 1'b0, 14, 13, 13,  0, 0};
    tbl[12] = '{8'h00, 8'h02, 1'b1, 16, 14, 14, 16, 1};
    tbl[13] = '{8'h00, 8'h04, 1'b1, 16, 14, 14, 16, 1};
    tbl[14] = '{8'h2c, 8'h04, 1'b0, 16, 14, 14, 16, 1};
    tbl[15] = '{8'h01, 8'h04, 1'b0, 16, 14, 14, 16, 0};
    tbl[16] = '{8'h00, 8'h04, 1'b0, 16, 14, 14, 16, 0};
    tbl[17] = '{8'h2c, 8'h04, 1'b0,  0,  0,  0, 16, 0};
    tbl[18] = '{8'h00, 8'h04, 1'b0,  0,  0,  0, 16, 0};
    Reset = 1'b0;
    bus.keycode = 8'h00;
    bus.score_in = 8'h00;
    bus.end_game = 1'b0;
    #12;
    chk("rst_score", int'(bus.score), 0);
    chk("rst_combo", int'(bus.combo), 0);
    chk("rst_high", int'(bus.high_score), 0);
    chk("rst_over", int'(bus.game_over), 0);
    Reset = 1'b1;
    for (int i = 0; i < 19; i++) begin
      e = '{tbl[i].sc, tbl[i].cb, tbl[i].mx, tbl[i].hs, tbl[i].go};
      run(tbl[i].kc, tbl[i].sin, tbl[i].eg, 1'b1, e);
    end
    step(8'h00, 8'h00, 1'b0);
    pulse(8'hff);
    pulse(8'h01);
    pulse(8'hff);
    pulse(8'h0f);
    chk("score_25", int'(bus.score), 25);
    step(8'h00, 8'h00, 1'b1);
    chk("high_25", int'(bus.high_score), 25);
    step(8'h01, 8'h00, 1'b0);
    step(8'h2c, 8'h00, 1'b0);
    pulse(8'hff);
    pulse(8'h03);
    pulse(8'hff);
    pulse(8'h7f);
    chk("score_40", int'(bus.score), 40);
    step(8'h00, 8'h00, 1'b1);
    chk("high_40", int'(bus.high_score), 40);
    chk("over_40", int'(bus.game_over), 1);
    step(8'h01, 8'h00, 1'b0);
    step(8'h2c, 8'h00, 1'b0);
    step(8'h00, 8'h01, 1'b0);
    for (int i = 1; i <= 120; i++) begin
      step(8'h00, 8'h01, 1'b0);
      if (i == 119) chk("combo_before_timeout", int'(bus.combo), 1);
    end
    chk("combo_timeout", int'(bus.combo), 0);
    chk("max_kept", int'(bus.max_combo), 1);
    step(8'h00, 8'h00, 1'b1);
    chk("high_not_lowered", int'(bus.high_score), 40);
    step(8'h01, 8'h00, 1'b0);
    step(8'h2c, 8'h00, 1'b0);
    pulse(8'hff);
    pulse(8'hff);
    for (int i = 0; i < 623; i++) pulse(8'hff);
    pulse(8'h7f);
    chk("score_9998", int'(bus.score), 9998);
    pulse(8'h03);
    chk("score_sat", int'(bus.score), 9999);
    pulse(8'hff);
    chk("score_sat_hold", int'(bus.score), 9999);
    chk("combo_sat", int'(bus.combo), 255);
    step(8'h00, 8'h00, 1'b1);
    chk("high_9999", int'(bus.high_score), 9999);
    step(8'h01, 8'h00, 1'b0);
    step(8'h2c, 8'h00, 1'b0);
    step(8'h00, 8'h01, 1'b0);
    #2;
    Reset = 1'b0;
    #1;
    chk("async_score", int'(bus.score), 0);
    chk("async_combo", int'(bus.combo), 0);
    chk("async_max", int'(bus.max_combo), 0);
    chk("async_high", int'(bus.high_score), 0);
    chk("async_over", int'(bus.game_over), 0);
    m_st = 0; m_score = 0; m_combo = 0; m_max = 0; m_hs = 0; m_tmo = 0; m_prev = '0;
    #3;
    Reset = 1'b1;
    step(8'h00, 8'h01, 1'b1);
    step(8'h2c, 8'h01, 1'b0);
    step(8'h00, 8'h03, 1'b0);
    chk("restart_score", int'(bus.score), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/score_tally.md
SCORE_TALLY -- requirements
Module: score_tally

Interface
REQ-001 The block SHALL have parameter N_LANES, default 8: number of dropper score flags consumed.
REQ-002 The block SHALL have parameter COMBO_TIMEOUT, default 120: frames without a hit before the combo clears.
REQ-003 The block SHALL have parameter BONUS_COMBO, default 10: combo level at and above which a hit is worth 2 points.
REQ-004 The block SHALL have parameter SCORE_MAX, default 9999: saturation value for score and high_score.
REQ-005 The block SHALL have port frame_clk, input, 1 bit: the single clock (one edge per video frame).
REQ-006 The block SHALL have port Reset, input, 1 bit: reset; one clock; reset is asynchronous and active-low.
REQ-007 The block SHALL have port keycode, input, 8 bits: primary key (8'h2c start, 8'h01 return to idle).
REQ-008 The block SHALL have port score_in, input, N_LANES bits: level-held hit flags, one per dropper.
REQ-009 The block SHALL have port end_game, input, 1 bit: level, high when the song/chart has finished.
REQ-010 The block SHALL have port score, output, 14 bits: current game score, binary.
REQ-011 The block SHALL have port combo, output, 8 bits: current consecutive-hit count.
REQ-012 The block SHALL have port max_combo, output, 8 bits: largest combo reached this game.
REQ-013 The block SHALL have port high_score, output, 14 bits: best score since reset.
REQ-014 The block SHALL have port game_over, output, 1 bit: high while in DONE.

Function
REQ-015 The block SHALL implement states IDLE, PLAYING, DONE; all outputs SHALL be registered on frame_clk.
REQ-016 In IDLE, keycode==8'h2c SHALL move to PLAYING on the next edge and clear score, combo, max_combo and timeout counter to 0.
REQ-017 In PLAYING, end_game==1 SHALL move to DONE on the next edge; in DONE, keycode==8'h01 SHALL move to IDLE.
REQ-018 The block SHALL register score_in into prev_in every edge in every state, so that flags already high on entry to PLAYING are not counted.
REQ-019 A hit SHALL be a lane with score_in=1 and prev_in=0 while in PLAYING; hits = popcount of such lanes (0..N_LANES), all counted in the same frame.
REQ-020 With hits>0, the points added SHALL be hits*1 when combo<BONUS_COMBO and hits*2 otherwise, judged on the pre-update combo value; score SHALL update one edge after the rising flag is sampled.
REQ-021 score SHALL saturate at SCORE_MAX and never wrap.
REQ-022 With hits>0, combo SHALL increase by hits and saturate at 255, and the timeout counter SHALL clear to 0.
REQ-023 With hits==0 in PLAYING, the timeout counter SHALL increment; when it reaches COMBO_TIMEOUT, combo and the counter SHALL clear to 0 on that edge.
REQ-024 max_combo SHALL track max(max_combo, new combo) on every edge in PLAYING.
REQ-025 On the PLAYING->DONE edge, high_score SHALL load score if score>high_score.
REQ-026 If end_game and hits occur on the same edge, the hits SHALL be scored first and the updated score SHALL be used for the high_score comparison.
REQ-027 In DONE and IDLE, score, combo and max_combo SHALL hold their values, and score_in edges SHALL be ignored.
REQ-028 keycode values other than those listed SHALL have no effect; 8'h2c in PLAYING or DONE SHALL be ignored.

Reset
REQ-029 Reset low SHALL immediately force state IDLE and set score, combo, max_combo, high_score, prev_in, the timeout counter and game_over to 0, independent of frame_clk.
REQ-030 Reset asserted mid-PLAYING SHALL discard the game without updating high_score; on release, the block SHALL stay in IDLE until 8'h2c.

Verification
REQ-031 Start, then raise lane 0 for 1 frame and hold it -> score=1 and combo=1 one edge later, with no further increment while the flag is held.
REQ-032 Raise lanes 0, 3 and 5 in the same frame with combo=9 -> score+=3 and combo=12; the next single hit adds 2.
REQ-033 After a hit, drive 120 hit-free frames -> combo=0 on the 120th edge, and max_combo is retained.
REQ-034 Preload the score to 9998 via hits, then hit 2 lanes at combo>=10 -> score=9999.
REQ-035 Hold lane 2 high in IDLE, then start -> the first frame in PLAYING adds no points; end_game with score 40 and high_score 25 -> high_score=40 and game_over=1.
REQ-036 Assert Reset mid-game between clock edges -> all outputs are 0 immediately, and high_score is not updated.
